// File: rtl/password_seq_ctrl.sv
// password_seq_ctrl
// ---------------------------------------------------------------------------
// Four-digit BCD code lock sequencer. Digits arrive one at a time on an
// 'enter' pulse. After the fourth digit the stored code is compared against
// PASSWORD. The lock then holds an unlocked, wrong-code or lockout
// indication for a fixed number of cycles, and returns to IDLE afterwards.
// After MAX_TRIES wrong codes the lock enters lockout, and the attempt
// budget is reloaded when lockout ends.
//
// Parameters
//   PASSWORD    : 4-digit BCD code, most significant digit first
//   MAX_TRIES   : wrong attempts allowed before lockout (1..3)
//   OPEN_CYCLES : cycles the unlocked indication is held
//   FAIL_CYCLES : cycles the wrong-code indication is held
//   LOCK_CYCLES : cycles of lockout
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   enter      in   one-shot "accept digit" pulse
//   clear      in   one-shot "abort entry / re-lock" pulse
//   digit      in   [3:0] BCD digit, sampled when enter=1
//   entered    out  [15:0] digits entered so far, newest digit in [3:0]
//   count      out  [2:0]  number of digits accepted (0..4)
//   unlocked   out  state is OPEN (registered)
//   fail       out  state is FAIL (registered)
//   locked     out  state is LOCKOUT (registered)
//   tries_left out  [1:0]  remaining attempts
//   state      out  [2:0]  FSM encoding for display
// ---------------------------------------------------------------------------
module password_seq_ctrl #(
    parameter logic [15:0] PASSWORD    = 16'h1234,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned OPEN_CYCLES = 150_000_000,
    parameter int unsigned FAIL_CYCLES = 50_000_000,
    parameter int unsigned LOCK_CYCLES = 250_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enter,
    input  logic        clear,
    input  logic [3:0]  digit,
    output logic [15:0] entered,
    output logic [2:0]  count,
    output logic        unlocked,
    output logic        fail,
    output logic        locked,
    output logic [1:0]  tries_left,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        FAIL    = 3'd4,
        LOCKOUT = 3'd5
    } state_t;

    // One shared timer serves all three timed states, so it is sized for
    // the longest one. It only has to hold N-1.
    localparam int unsigned MAX_OF_OF = (OPEN_CYCLES > FAIL_CYCLES) ? OPEN_CYCLES : FAIL_CYCLES;
    localparam int unsigned MAX_N     = (MAX_OF_OF > LOCK_CYCLES) ? MAX_OF_OF : LOCK_CYCLES;
    localparam int unsigned TW        = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    localparam logic [TW-1:0] OPEN_LOAD  = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] FAIL_LOAD  = TW'(FAIL_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LOAD  = TW'(LOCK_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ZERO = TW'(0);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [1:0]    TRIES_INIT = 2'(MAX_TRIES);

    state_t         state_r;
    state_t         state_s;
    logic [TW-1:0]  timer_r;
    logic [TW-1:0]  timer_s;
    logic [15:0]    entered_s;
    logic [2:0]     count_s;
    logic [1:0]     tries_s;

    // True when the digit is a legal BCD value (0..9).
    function automatic logic is_bcd(input logic [3:0] d);
        return (d <= 4'd9);
    endfunction

    assign state = state_r;

    // State, datapath and status register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            entered    <= 16'h0000;
            count      <= 3'd0;
            tries_left <= TRIES_INIT;
            timer_r    <= TIMER_ZERO;
            unlocked   <= 1'b0;
            fail       <= 1'b0;
            locked     <= 1'b0;
        end else begin
            state_r    <= state_s;
            entered    <= entered_s;
            count      <= count_s;
            tries_left <= tries_s;
            timer_r    <= timer_s;
            // Status flags are decoded from the next state. This makes the
            // registered flags track the state register cycle for cycle.
            unlocked   <= (state_s == OPEN);
            fail       <= (state_s == FAIL);
            locked     <= (state_s == LOCKOUT);
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_s   = state_r;
        entered_s = entered;
        count_s   = count;
        tries_s   = tries_left;
        timer_s   = timer_r;

        case (state_r)
            IDLE, ENTRY: begin
                // clear has priority over a same-cycle enter.
                if (clear) begin
                    state_s   = IDLE;
                    entered_s = 16'h0000;
                    count_s   = 3'd0;
                end else if (enter && is_bcd(digit)) begin
                    entered_s = {entered[11:0], digit};
                    count_s   = count + 3'd1;
                    if (count_s == 3'd4) begin
                        state_s = CHECK;
                    end else begin
                        state_s = ENTRY;
                    end
                end else begin
                    state_s = state_r;
                end
            end

            CHECK: begin
                if (entered == PASSWORD) begin
                    state_s = OPEN;
                    tries_s = TRIES_INIT;
                    timer_s = OPEN_LOAD;
                end else begin
                    tries_s = tries_left - 2'd1;
                    if (tries_s == 2'd0) begin
                        state_s = LOCKOUT;
                        timer_s = LOCK_LOAD;
                    end else begin
                        state_s = FAIL;
                        timer_s = FAIL_LOAD;
                    end
                end
            end

            OPEN: begin
                // clear re-locks early. enter is ignored while the lock is open.
                if (clear || (timer_r == TIMER_ZERO)) begin
                    state_s   = IDLE;
                    entered_s = 16'h0000;
                    count_s   = 3'd0;
                    timer_s   = TIMER_ZERO;
                end else begin
                    timer_s = timer_r - TIMER_ONE;
                end
            end

            FAIL: begin
                if (timer_r == TIMER_ZERO) begin
                    state_s   = IDLE;
                    entered_s = 16'h0000;
                    count_s   = 3'd0;
                end else begin
                    timer_s = timer_r - TIMER_ONE;
                end
            end

            LOCKOUT: begin
                // The attempt budget is refilled only when lockout expires.
                if (timer_r == TIMER_ZERO) begin
                    state_s   = IDLE;
                    entered_s = 16'h0000;
                    count_s   = 3'd0;
                    tries_s   = TRIES_INIT;
                end else begin
                    timer_s = timer_r - TIMER_ONE;
                end
            end

            default: begin
                // Encodings 6 and 7 are unused. They recover to a clean IDLE.
                state_s   = IDLE;
                entered_s = 16'h0000;
                count_s   = 3'd0;
                timer_s   = TIMER_ZERO;
            end
        endcase
    end

endmodule
